// File: rtl/image_loader.sv
// Byte-stream to pixel loader: assembles R,G,B bytes into 24-bit pixels and
// drives row-major writes into the external 64x64 input image memory.
module image_loader #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_data,
   input  logic              i_valid,
   input  logic              i_sof,
   output logic              o_ready,
   input  logic              i_restart,
   output logic [ADDR_W-1:0] o_wr_row,
   output logic [ADDR_W-1:0] o_wr_col,
   output logic [23:0]       o_wr_pix,
   output logic              o_wr_we,
   output logic              o_load_done,
   output logic              o_frame_err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BYTE_R = 3'd1,
      BYTE_G = 3'd2,
      BYTE_B = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);

   state_t            r_state;
   state_t            w_nextState;

   logic [7:0]        r_red;
   logic [7:0]        r_green;
   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_col;
   logic [23:0]       r_pix;
   logic              r_we;
   logic              r_done;
   logic              r_err;

   logic              w_ready;
   logic              w_accept;
   logic              w_inPixel;
   logic              w_atOrigin;
   logic              w_resync;
   logic              w_lastPixel;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (i_restart) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && i_sof) begin
                  w_nextState = BYTE_G;
               end
            end
            BYTE_R: begin
               if (w_accept) begin
                  w_nextState = BYTE_G;
               end
            end
            BYTE_G: begin
               if (w_accept) begin
                  w_nextState = i_sof ? BYTE_G : BYTE_B;
               end
            end
            BYTE_B: begin
               if (w_accept) begin
                  w_nextState = i_sof ? BYTE_G : WRITE;
               end
            end
            WRITE: begin
               w_nextState = w_lastPixel ? DONE : BYTE_R;
            end
            DONE: begin
               w_nextState = DONE;
            end
            default: begin
               w_nextState = IDLE;
            end
         endcase
      end
   end

   // A start-of-frame byte is only legitimate as the very first R byte; anywhere
   // else inside a frame it forces a resync to pixel (0,0) and flags the error.
   always_comb begin
      w_ready     = 1'b0;
      w_inPixel   = 1'b0;
      case (r_state)
         IDLE:    w_ready = 1'b1;
         BYTE_R,
         BYTE_G,
         BYTE_B: begin
            w_ready   = 1'b1;
            w_inPixel = 1'b1;
         end
         default: begin
            w_ready   = 1'b0;
            w_inPixel = 1'b0;
         end
      endcase
      w_accept    = i_valid && w_ready;
      w_atOrigin  = (r_state == BYTE_R) && (r_row == '0) && (r_col == '0);
      w_resync    = w_accept && i_sof && w_inPixel && !w_atOrigin;
      w_lastPixel = (r_row == LAST_ROW) && (r_col == LAST_COL);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_red   <= '0;
         r_green <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_pix   <= '0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else if (i_restart) begin
         r_row   <= '0;
         r_col   <= '0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            IDLE,
            BYTE_R,
            BYTE_G,
            BYTE_B: begin
               if (w_accept && i_sof) begin
                  r_red <= i_data;
                  r_row <= '0;
                  r_col <= '0;
                  if (w_resync) begin
                     r_err <= 1'b1;
                  end
               end else if (w_accept) begin
                  case (r_state)
                     BYTE_R: r_red   <= i_data;
                     BYTE_G: r_green <= i_data;
                     BYTE_B: begin
                        r_pix <= {r_red, r_green, i_data};
                        r_we  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            WRITE: begin
               if (w_lastPixel) begin
                  r_done <= 1'b1;
               end else if (r_col == LAST_COL) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready     = w_ready;
   assign o_wr_row    = r_row;
   assign o_wr_col    = r_col;
   assign o_wr_pix    = r_pix;
   assign o_wr_we     = r_we;
   assign o_load_done = r_done;
   assign o_frame_err = r_err;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: a scoreboard of expected (row,col,pixel)
// writes is built from the bytes the bench sends and checked at every wr_we.
module tb_image_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] inData = '0;
   logic       inValid = 1'b0;
   logic       inSof = 1'b0;
   logic       restart = 1'b0;
   logic       inReady;
   logic [5:0] wrRow;
   logic [5:0] wrCol;
   logic [23:0] wrPix;
   logic       wrWe;
   logic       loadDone;
   logic       frameErr;

   int checks = 0;
   int failures = 0;
   int wrCount = 0;
   logic [35:0] expQ [$];
   logic [35:0] expW;
   logic [23:0] capMem [4096];

   image_loader #(.IMG_W(64), .IMG_H(64), .ADDR_W(6)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_data(inData),
      .i_valid(inValid),
      .i_sof(inSof),
      .o_ready(inReady),
      .i_restart(restart),
      .o_wr_row(wrRow),
      .o_wr_col(wrCol),
      .o_wr_pix(wrPix),
      .o_wr_we(wrWe),
      .o_load_done(loadDone),
      .o_frame_err(frameErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] refPix(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, 8'h5A};
   endfunction

   function automatic logic [35:0] expEntry(input int idx, input logic [23:0] p);
      return {6'(idx / 64), 6'(idx % 64), p};
   endfunction

   task automatic waitCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one byte and hold it until the loader takes it (bounded wait).
   task automatic applyStimulus(input logic [7:0] d, input logic s, input bit gaps);
      int waitCnt;
      if (gaps) begin
         for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) begin
            inValid = 1'b0;
            waitCycles(1);
         end
      end
      inValid = 1'b1;
      inData  = d;
      inSof   = s;
      waitCnt = 0;
      while (inReady !== 1'b1 && waitCnt < 20) begin
         waitCycles(1);
         waitCnt++;
      end
      if (inReady !== 1'b1) begin
         checkOutput("readyTimeout", 64'(inReady), 64'd1);
      end else begin
         waitCycles(1);
      end
      inValid = 1'b0;
      inSof   = 1'b0;
   endtask

   task automatic sendPixel(input int idx, input logic [23:0] p, input bit sof, input bit gaps);
      applyStimulus(p[23:16], sof, gaps);
      applyStimulus(p[15:8], 1'b0, gaps);
      applyStimulus(p[7:0], 1'b0, gaps);
      expQ.push_back(expEntry(idx, p));
   endtask

   task automatic sendFrame(input bit gaps);
      for (int i = 0; i < 4096; i++) begin
         sendPixel(i, refPix(i), i == 0, gaps);
      end
   endtask

   task automatic pulseRestart(input bit withValid);
      restart = 1'b1;
      inValid = withValid;
      inSof   = withValid;
      inData  = 8'($urandom);
      waitCycles(1);
      restart = 1'b0;
      inValid = 1'b0;
      inSof   = 1'b0;
   endtask

   // Every write must match the head of the expected-write queue.
   always @(negedge clk) begin
      if (wrWe === 1'b1) begin
         wrCount++;
         capMem[int'(wrRow) * 64 + int'(wrCol)] = wrPix;
         checkOutput("wrExpected", 64'(expQ.size() != 0), 64'd1);
         if (expQ.size() != 0) begin
            expW = expQ.pop_front();
            checkOutput("wrAddrPix", 64'({wrRow, wrCol, wrPix}), 64'(expW));
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [23:0] p;
      logic [23:0] pk;

      $display("[TB] reset");
      waitCycles(2);
      checkOutput("rstRowColPix", 64'({wrRow, wrCol, wrPix}), 64'd0);
      checkOutput("rstFlags", 64'({wrWe, loadDone, frameErr}), 64'd0);
      rst = 1'b0;
      waitCycles(1);
      checkOutput("idleReady", 64'(inReady), 64'd1);

      $display("[TB] test1 full frame, valid held");
      wrCount = 0;
      for (int i = 0; i < 4095; i++) begin
         sendPixel(i, refPix(i), i == 0, 1'b0);
      end
      sendPixel(4095, refPix(4095), 1'b0, 1'b0);
      checkOutput("lastWriteWe", 64'(wrWe), 64'd1);
      checkOutput("doneNotYet", 64'(loadDone), 64'd0);
      waitCycles(1);
      checkOutput("doneRises", 64'(loadDone), 64'd1);
      checkOutput("doneAddr", 64'({wrRow, wrCol}), 64'hFFF);
      checkOutput("doneWeLow", 64'(wrWe), 64'd0);
      inValid = 1'b1;
      inData  = 8'h33;
      waitCycles(4);
      checkOutput("doneNotReady", 64'(inReady), 64'd0);
      inValid = 1'b0;
      checkOutput("t1WrCount", 64'(wrCount), 64'd4096);
      checkOutput("t1Pix01", 64'(capMem[1]), 64'h01FE5A);
      checkOutput("t1Drained", 64'(expQ.size()), 64'd0);

      $display("[TB] test6 restart in DONE with valid");
      pulseRestart(1'b1);
      checkOutput("t6Done", 64'(loadDone), 64'd0);
      checkOutput("t6Ready", 64'(inReady), 64'd1);
      checkOutput("t6Addr", 64'({wrRow, wrCol, frameErr}), 64'd0);
      applyStimulus(8'($urandom), 1'b0, 1'b0);
      applyStimulus(8'($urandom), 1'b0, 1'b0);
      waitCycles(4);
      checkOutput("t6NoWrite", 64'(expQ.size() == 0 && wrWe == 1'b0), 64'd1);
      checkOutput("t6StillIdle", 64'(inReady), 64'd1);

      $display("[TB] test3 discard pre-sof bytes");
      wrCount = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'($urandom), 1'b0, 1'b0);
      end
      checkOutput("t3NoEarlyWrite", 64'(wrCount), 64'd0);
      for (int i = 0; i < 3; i++) begin
         sendPixel(i, 24'($urandom), i == 0, 1'b0);
      end
      waitCycles(3);
      checkOutput("t3WrCount", 64'(wrCount), 64'd3);
      checkOutput("t3Drained", 64'(expQ.size()), 64'd0);
      pulseRestart(1'b0);

      $display("[TB] test4 sof mid-frame");
      for (int i = 0; i <= 133; i++) begin
         sendPixel(i, 24'($urandom), i == 0, 1'b0);
      end
      p = 24'($urandom);
      applyStimulus(p[23:16], 1'b0, 1'b0);
      applyStimulus(p[15:8], 1'b0, 1'b0);
      checkOutput("t4ErrBefore", 64'(frameErr), 64'd0);
      pk = 24'($urandom);
      applyStimulus(pk[23:16], 1'b1, 1'b0);
      checkOutput("t4ErrSet", 64'(frameErr), 64'd1);
      checkOutput("t4AddrReset", 64'({wrRow, wrCol, wrWe}), 64'd0);
      applyStimulus(pk[15:8], 1'b0, 1'b0);
      applyStimulus(pk[7:0], 1'b0, 1'b0);
      expQ.push_back(expEntry(0, pk));
      waitCycles(3);
      checkOutput("t4Drained", 64'(expQ.size()), 64'd0);
      checkOutput("t4ErrSticky", 64'(frameErr), 64'd1);
      pulseRestart(1'b0);
      checkOutput("t4ErrCleared", 64'(frameErr), 64'd0);

      $display("[TB] test2 random valid gaps");
      for (int i = 0; i < 4096; i++) capMem[i] = 24'hFFFFFF;
      wrCount = 0;
      sendFrame(1'b1);
      waitCycles(2);
      checkOutput("t2Done", 64'(loadDone), 64'd1);
      checkOutput("t2WrCount", 64'(wrCount), 64'd4096);
      for (int i = 0; i < 4096; i++) begin
         checkOutput("t2Image", 64'(capMem[i]), 64'(refPix(i)));
      end
      pulseRestart(1'b0);

      $display("[TB] test5 reset mid-frame");
      for (int i = 0; i < 650; i++) begin
         sendPixel(i, 24'($urandom), i == 0, 1'b0);
      end
      p = 24'($urandom);
      applyStimulus(p[23:16], 1'b0, 1'b0);
      applyStimulus(p[15:8], 1'b0, 1'b0);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("t5RstOuts", 64'({wrRow, wrCol, wrPix, wrWe, loadDone, frameErr}), 64'd0);
      rst = 1'b0;
      waitCycles(5);
      checkOutput("t5NoWrite", 64'(expQ.size() == 0 && wrWe == 1'b0), 64'd1);
      sendFrame(1'b0);
      waitCycles(2);
      checkOutput("t5Done", 64'(loadDone), 64'd1);
      checkOutput("t5NoErr", 64'(frameErr), 64'd0);
      checkOutput("t5Drained", 64'(expQ.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
